// File: rtl/econet_link_ctrl_pkg.sv
// econet_link_ctrl_pkg: shared state encodings, LFSR constants and backoff scale
package econet_link_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_TX        = 3'd2,
    ST_ACK_WAIT  = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_NOCLK     = 3'd5
  } state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // backoff is the LFSR sample scaled by 16
  localparam int BACKOFF_SHIFT = 4;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/econet_link_ctrl_sync2.sv
// econet_link_ctrl_sync2: two-flop level synchronizer with async reset
module econet_link_ctrl_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  // shift the raw level through two flops
  always_ff @(posedge clk or posedge reset)
    if (reset) {r_q, r_meta} <= 2'b00;
    else       {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/econet_link_ctrl.sv
// econet_link_ctrl: Econet line arbitration, ack/retry handling and receive-buffer ownership
module econet_link_ctrl
  import econet_link_ctrl_pkg::*;
#(
  parameter int IDLE_GAP    = 64,
  parameter int ACK_TIMEOUT = 2000,
  parameter int RETRY_MAX   = 3,
  parameter int BACKOFF_W   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idle_in,
  input  logic       no_clock_in,
  input  logic       frame_complete,
  input  logic       frame_valid,
  input  logic       abort,
  input  logic       tx_req,
  input  logic       tx_done,
  input  logic       host_rx_release,
  output logic       tx_start,
  output logic       tx_grant,
  output logic       tx_ok,
  output logic       tx_fail,
  output logic       rx_frame_ready,
  output logic       rx_frame_ok,
  output logic       rx_overrun,
  output logic [7:0] abort_count,
  output logic [1:0] retry_count,
  output logic [2:0] state,
  output logic       irq
);
  localparam int IC_W = $clog2(IDLE_GAP + 1);
  localparam int TM_W = $clog2(ACK_TIMEOUT);
  localparam int BO_W = BACKOFF_W + BACKOFF_SHIFT;

  logic                 w_idle_s, w_noclk_s, w_line_free;
  logic [IC_W-1:0]      r_idle_cnt;
  logic [15:0]          r_lfsr;
  state_t               r_state, w_next;
  logic [TM_W-1:0]      r_timer, w_timer_n;
  logic [BO_W-1:0]      r_bo, w_bo_n;
  logic [BACKOFF_W-1:0] w_bo_seed;
  logic [1:0]           r_retry, w_retry_n;
  logic                 w_ack, w_nak, w_last;
  logic                 w_start_n, w_grant_n, w_ok_n, w_fail_n;
  logic                 r_tx_start, r_tx_grant, r_tx_ok, r_tx_fail;
  logic                 w_rdy_kept, w_rdy_n, w_rok_n, w_ovr_n;
  logic                 r_rdy, r_rok, r_ovr, r_irq;
  logic [7:0]           r_abort_cnt;

  econet_link_ctrl_sync2 u_sync_idle  (.clk(clk), .reset(reset), .i_d(idle_in),     .o_q(w_idle_s));
  econet_link_ctrl_sync2 u_sync_noclk (.clk(clk), .reset(reset), .i_d(no_clock_in), .o_q(w_noclk_s));

  // count consecutive synchronized idle cycles, saturating at the gap
  always_ff @(posedge clk or posedge reset)
    if (reset)                                r_idle_cnt <= '0;
    else if (!w_idle_s)                       r_idle_cnt <= '0;
    else if (r_idle_cnt != IC_W'(IDLE_GAP))   r_idle_cnt <= r_idle_cnt + IC_W'(1);

  assign w_line_free = (r_idle_cnt == IC_W'(IDLE_GAP)) & ~w_noclk_s;

  // free-running backoff randomiser
  always_ff @(posedge clk or posedge reset)
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);

  assign w_ack     = frame_complete & frame_valid;
  assign w_nak     = abort | (frame_complete & ~frame_valid) | (r_timer == TM_W'(ACK_TIMEOUT - 1));
  assign w_last    = r_retry == 2'(RETRY_MAX - 1);
  assign w_bo_seed = (r_lfsr[BACKOFF_W-1:0] == '0) ? BACKOFF_W'(1) : r_lfsr[BACKOFF_W-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;

  // FSM next state; clock loss overrides every state
  always_comb begin
    w_next = r_state;
    if (w_noclk_s) w_next = ST_NOCLK;
    else
      case (r_state)
        ST_IDLE:      w_next = tx_req ? ST_WAIT_LINE : ST_IDLE;
        ST_WAIT_LINE: w_next = !tx_req ? ST_IDLE : w_line_free ? ST_TX : ST_WAIT_LINE;
        ST_TX:        w_next = tx_done ? ST_ACK_WAIT : ST_TX;
        ST_ACK_WAIT:  w_next = w_ack ? ST_IDLE : !w_nak ? ST_ACK_WAIT : w_last ? ST_IDLE : ST_BACKOFF;
        ST_BACKOFF:   w_next = (r_bo <= BO_W'(1)) ? ST_WAIT_LINE : ST_BACKOFF;
        default:      w_next = ST_IDLE;
      endcase
  end

  // FSM outputs and datapath next values derived from the transition
  always_comb begin
    w_grant_n = w_next == ST_TX;
    w_start_n = (r_state == ST_WAIT_LINE) && (w_next == ST_TX);
    w_ok_n    = (r_state == ST_ACK_WAIT) && !w_noclk_s && w_ack;
    w_fail_n  = w_noclk_s ? (r_state != ST_IDLE && r_state != ST_NOCLK)
                          : (r_state == ST_ACK_WAIT && !w_ack && w_nak && w_last);
    w_timer_n = (r_state == ST_ACK_WAIT) ? r_timer + TM_W'(1) : '0;
    w_retry_n = (r_state == ST_IDLE && w_next == ST_WAIT_LINE) ? 2'd0 :
                (r_state == ST_ACK_WAIT && w_next == ST_BACKOFF) ? r_retry + 2'd1 : r_retry;
    w_bo_n    = (r_state == ST_ACK_WAIT && w_next == ST_BACKOFF) ? {w_bo_seed, {BACKOFF_SHIFT{1'b0}}} :
                (r_state == ST_BACKOFF) ? r_bo - BO_W'(1) : r_bo;
  end

  // register transmit-side outputs and counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_grant <= 1'b0;
      r_tx_ok    <= 1'b0;
      r_tx_fail  <= 1'b0;
      r_timer    <= '0;
      r_retry    <= '0;
      r_bo       <= '0;
    end else begin
      r_tx_start <= w_start_n;
      r_tx_grant <= w_grant_n;
      r_tx_ok    <= w_ok_n;
      r_tx_fail  <= w_fail_n;
      r_timer    <= w_timer_n;
      r_retry    <= w_retry_n;
      r_bo       <= w_bo_n;
    end

  // receive buffer: a release frees the buffer before a coincident frame is considered
  always_comb begin
    w_rdy_kept = r_rdy & ~host_rx_release;
    w_rdy_n    = w_rdy_kept | frame_complete;
    w_rok_n    = (frame_complete & ~w_rdy_kept) ? frame_valid : (r_rok & ~host_rx_release);
    w_ovr_n    = (r_ovr & ~host_rx_release) | (frame_complete & w_rdy_kept);
  end

  // register receive-side status, interrupt and abort counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rdy       <= 1'b0;
      r_rok       <= 1'b0;
      r_ovr       <= 1'b0;
      r_irq       <= 1'b0;
      r_abort_cnt <= '0;
    end else begin
      r_rdy       <= w_rdy_n;
      r_rok       <= w_rok_n;
      r_ovr       <= w_ovr_n;
      r_irq       <= w_rdy_n | w_ovr_n;
      r_abort_cnt <= r_abort_cnt + 8'(abort && r_abort_cnt != 8'hFF);
    end

  assign tx_start       = r_tx_start;
  assign tx_grant       = r_tx_grant;
  assign tx_ok          = r_tx_ok;
  assign tx_fail        = r_tx_fail;
  assign rx_frame_ready = r_rdy;
  assign rx_frame_ok    = r_rok;
  assign rx_overrun     = r_ovr;
  assign abort_count    = r_abort_cnt;
  assign retry_count    = r_retry;
  assign state          = r_state;
  assign irq            = r_irq;
endmodule

// File: tb/tb_econet_link_ctrl.sv
// tb_econet_link_ctrl: directed self-checking bench for econet_link_ctrl
module tb_econet_link_ctrl;
  logic clk = 0, reset = 1, idle_in = 0, no_clock_in = 0, frame_complete = 0, frame_valid = 0;
  logic abort = 0, tx_req = 0, tx_done = 0, host_rx_release = 0;
  logic tx_start, tx_grant, tx_ok, tx_fail, rx_frame_ready, rx_frame_ok, rx_overrun, irq;
  logic [7:0] abort_count;
  logic [1:0] retry_count;
  logic [2:0] state;
  logic [15:0] m_lfsr;
  int errors = 0, checks = 0;

  econet_link_ctrl dut (
    .clk(clk), .reset(reset), .idle_in(idle_in), .no_clock_in(no_clock_in),
    .frame_complete(frame_complete), .frame_valid(frame_valid), .abort(abort),
    .tx_req(tx_req), .tx_done(tx_done), .host_rx_release(host_rx_release),
    .tx_start(tx_start), .tx_grant(tx_grant), .tx_ok(tx_ok), .tx_fail(tx_fail),
    .rx_frame_ready(rx_frame_ready), .rx_frame_ok(rx_frame_ok), .rx_overrun(rx_overrun),
    .abort_count(abort_count), .retry_count(retry_count), .state(state), .irq(irq)
  );

  always #5 clk = ~clk;

  // reference LFSR: Fibonacci, taps 16,14,13,11, seed ACE1
  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  function automatic logic [20:0] all_outs();
    return {tx_start, tx_grant, tx_ok, tx_fail, rx_frame_ready, rx_frame_ok, rx_overrun,
            abort_count, retry_count, state, irq};
  endfunction

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks++; if (all_outs() !== 21'd0) begin errors++; $display("FAIL reset_outs got=%0h exp=0", all_outs()); end
    reset = 0;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
  endtask

  task automatic test_grant;
    logic early;
    early = 0;
    idle_in = 1; tx_req = 1;
    for (int i = 0; i < 30; i++) begin @(negedge clk); early |= tx_start; end
    idle_in = 0;
    @(negedge clk); early |= tx_start;
    idle_in = 1;
    for (int i = 1; i <= 66; i++) begin @(negedge clk); early |= tx_start; end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL grant_early got=%0b exp=0", early); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL grant_start67 got=%0b exp=1", tx_start); end
    checks++; if (tx_grant !== 1'b1) begin errors++; $display("FAIL grant_level got=%0b exp=1", tx_grant); end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL grant_state got=%0d exp=2", state); end
    @(negedge clk);
    checks++; if ({tx_start, tx_grant} !== 2'b01) begin errors++; $display("FAIL grant_pulse got=%0b exp=01", {tx_start, tx_grant}); end
  endtask

  task automatic test_ack;
    repeat (5) @(negedge clk);
    tx_done = 1; @(negedge clk); tx_done = 0;
    checks++; if ({state, tx_grant} !== {3'd3, 1'b0}) begin errors++; $display("FAIL ack_enter got=%0h exp=6", {state, tx_grant}); end
    repeat (499) @(negedge clk);
    frame_complete = 1; frame_valid = 1; tx_req = 0;
    @(negedge clk); frame_complete = 0; frame_valid = 0;
    checks++; if (tx_ok !== 1'b1) begin errors++; $display("FAIL ack_ok got=%0b exp=1", tx_ok); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ack_state got=%0d exp=0", state); end
    checks++; if ({rx_frame_ready, rx_frame_ok, irq} !== 3'b111) begin errors++; $display("FAIL ack_rx got=%0b exp=111", {rx_frame_ready, rx_frame_ok, irq}); end
    @(negedge clk);
    checks++; if ({tx_ok, state} !== 4'd0) begin errors++; $display("FAIL ack_after got=%0h exp=0", {tx_ok, state}); end
    host_rx_release = 1; @(negedge clk); host_rx_release = 0;
    checks++; if ({rx_frame_ready, irq} !== 2'b00) begin errors++; $display("FAIL ack_release got=%0b exp=00", {rx_frame_ready, irq}); end
  endtask

  task automatic test_retry;
    int n, exp_len;
    logic [15:0] lf;
    tx_req = 1;
    for (int a = 0; a < 3; a++) begin
      n = 0;
      while (state !== 3'd2 && n < 200) begin @(negedge clk); n++; end
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL retry_tx%0d got=%0d exp=2", a, state); end
      tx_done = 1; @(negedge clk); tx_done = 0;
      n = 0; lf = m_lfsr;
      while (state === 3'd3 && n < 3000) begin lf = m_lfsr; @(negedge clk); n++; end
      checks++; if (n !== 2000) begin errors++; $display("FAIL retry_timeout%0d got=%0d exp=2000", a, n); end
      if (a < 2) begin
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL retry_backoff%0d got=%0d exp=4", a, state); end
        checks++; if (retry_count !== 2'(a + 1)) begin errors++; $display("FAIL retry_count%0d got=%0d exp=%0d", a, retry_count, a + 1); end
        exp_len = (lf[5:0] == 6'd0 ? 1 : int'(lf[5:0])) * 16;
        n = 0;
        while (state === 3'd4 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (n !== exp_len) begin errors++; $display("FAIL retry_bolen%0d got=%0d exp=%0d", a, n, exp_len); end
      end else begin
        tx_req = 0;
        checks++; if ({tx_fail, state} !== {1'b1, 3'd0}) begin errors++; $display("FAIL retry_fail got=%0h exp=8", {tx_fail, state}); end
        @(negedge clk);
        checks++; if (tx_fail !== 1'b0) begin errors++; $display("FAIL retry_fail_pulse got=%0b exp=0", tx_fail); end
      end
    end
  endtask

  task automatic test_noclk;
    int n, fails;
    tx_req = 1; n = 0;
    while (state !== 3'd2 && n < 200) begin @(negedge clk); n++; end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL noclk_tx got=%0d exp=2", state); end
    no_clock_in = 1; fails = 0;
    repeat (3) begin @(negedge clk); fails += int'(tx_fail); end
    checks++; if ({tx_grant, state} !== {1'b0, 3'd5}) begin errors++; $display("FAIL noclk_enter got=%0h exp=5", {tx_grant, state}); end
    repeat (5) begin @(negedge clk); fails += int'(tx_fail); end
    checks++; if (fails !== 1) begin errors++; $display("FAIL noclk_failcnt got=%0d exp=1", fails); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL noclk_hold got=%0d exp=5", state); end
    tx_req = 0; no_clock_in = 0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL noclk_exit got=%0d exp=0", state); end
  endtask

  task automatic test_rx;
    frame_complete = 1; frame_valid = 1; @(negedge clk); frame_complete = 0; frame_valid = 0;
    checks++; if ({rx_frame_ready, rx_frame_ok, rx_overrun} !== 3'b110) begin errors++; $display("FAIL rx_first got=%0b exp=110", {rx_frame_ready, rx_frame_ok, rx_overrun}); end
    frame_complete = 1; @(negedge clk); frame_complete = 0;
    checks++; if ({rx_frame_ready, rx_frame_ok, rx_overrun, irq} !== 4'b1111) begin errors++; $display("FAIL rx_overrun got=%0b exp=1111", {rx_frame_ready, rx_frame_ok, rx_overrun, irq}); end
    frame_complete = 1; host_rx_release = 1; @(negedge clk); frame_complete = 0; host_rx_release = 0;
    checks++; if ({rx_frame_ready, rx_frame_ok, rx_overrun} !== 3'b100) begin errors++; $display("FAIL rx_coincide got=%0b exp=100", {rx_frame_ready, rx_frame_ok, rx_overrun}); end
    host_rx_release = 1; @(negedge clk); host_rx_release = 0;
    checks++; if ({rx_frame_ready, irq} !== 2'b00) begin errors++; $display("FAIL rx_release got=%0b exp=00", {rx_frame_ready, irq}); end
  endtask

  task automatic test_abort;
    for (int i = 1; i <= 300; i++) begin
      abort = 1; @(negedge clk); abort = 0; @(negedge clk);
      if (i == 100) begin
        checks++; if (abort_count !== 8'd100) begin errors++; $display("FAIL abort_100 got=%0d exp=100", abort_count); end
      end
    end
    checks++; if (abort_count !== 8'd255) begin errors++; $display("FAIL abort_sat got=%0d exp=255", abort_count); end
  endtask

  task automatic test_reset_mid;
    int n;
    tx_req = 1; n = 0;
    while (state !== 3'd2 && n < 200) begin @(negedge clk); n++; end
    tx_done = 1; @(negedge clk); tx_done = 0; tx_req = 0;
    abort = 1; @(negedge clk); abort = 0;
    checks++; if ({state, retry_count} !== {3'd4, 2'd1}) begin errors++; $display("FAIL rstmid_backoff got=%0h exp=11", {state, retry_count}); end
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++; if (all_outs() !== 21'd0) begin errors++; $display("FAIL rstmid_async got=%0h exp=0", all_outs()); end
    @(negedge clk); reset = 0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", state); end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_ack();
    test_retry();
    test_noclk();
    test_rx();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/econet_link_ctrl.md
Name: econet_link_ctrl

Overview:
Link-level controller that shares the half-duplex Econet line between the host transmit path and the receiver. It consumes the clk-domain receive events (frame_complete, abort, frame_valid) plus the raw idle and no_clock levels. It grants the transmitter only after a configurable idle gap, then waits for the acknowledge frame and retries with pseudo-random backoff. It also tracks receive-buffer ownership for the host and raises an interrupt.

Parameters:
IDLE_GAP, 64, consecutive clk cycles of synchronized idle required before transmit is granted
ACK_TIMEOUT, 2000, clk cycles allowed in ACK_WAIT before a retry
RETRY_MAX, 3, total transmit attempts before tx_fail
BACKOFF_W, 6, width of backoff count taken from the LFSR

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-high
idle_in  in  1  raw line-idle level from deframer (netclk domain, unsynchronized)
no_clock_in  in  1  clock-loss level from clock detector
frame_complete  in  1  one-clk pulse, end of received frame
frame_valid  in  1  level, CRC/framing good for the last frame, sampled with frame_complete
abort  in  1  one-clk pulse, receive abort
tx_req  in  1  host level request to transmit
tx_done  in  1  one-clk pulse from transmitter, frame fully sent
host_rx_release  in  1  one-clk pulse, host has emptied the receive buffer
tx_start  out  1  one-clk pulse, start transmitter
tx_grant  out  1  level, transmitter owns line
tx_ok  out  1  one-clk pulse, acknowledged
tx_fail  out  1  one-clk pulse, retries exhausted or clock lost
rx_frame_ready  out  1  level, receive buffer holds a frame for the host
rx_frame_ok  out  1  frame_valid latched with the held frame
rx_overrun  out  1  sticky, a frame arrived while the buffer was full
abort_count  out  8  saturating count of abort pulses
retry_count  out  2  attempts used in the current transaction
state  out  3  FSM state encoding, for status
irq  out  1  rx_frame_ready | rx_overrun

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, LFSR 16'hACE1, sync flops 0.
- idle_in and no_clock_in each pass through a 2-flop synchronizer (idle_s, noclk_s); latency is 2 clk.
- idle_cnt increments while idle_s=1, saturates at IDLE_GAP, and clears to 0 on any cycle with idle_s=0. line_free = (idle_cnt==IDLE_GAP) & !noclk_s.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clk.
- FSM states: IDLE=0, WAIT_LINE=1, TX=2, ACK_WAIT=3, BACKOFF=4, NOCLK=5.
  - IDLE: on tx_req go to WAIT_LINE with retry_count=0.
  - WAIT_LINE: if tx_req=0, return to IDLE (cancel, no pulse). If line_free, pulse tx_start, set tx_grant=1, go to TX.
  - TX: tx_grant=1 stays held. On tx_done, drop tx_grant, clear the timer, go to ACK_WAIT.
  - ACK_WAIT:
    - frame_complete with frame_valid=1: pulse tx_ok and go to IDLE.
    - abort, frame_complete with frame_valid=0, or timer==ACK_TIMEOUT-1: count the attempt. If retry_count==RETRY_MAX-1, pulse tx_fail and go to IDLE. Otherwise increment retry_count, load the backoff counter with max(1, lfsr[BACKOFF_W-1:0])*16, and go to BACKOFF.
    - A valid ack in the same cycle as timer expiry counts as an ack.
  - BACKOFF: decrement the backoff counter each clk; at 0 go to WAIT_LINE.
  - Any state with noclk_s=1: go to NOCLK and drop tx_grant the same cycle. If the prior state was not IDLE, pulse tx_fail once. NOCLK returns to IDLE when noclk_s=0.
- tx_done outside TX is ignored. tx_req deassertion is ignored outside WAIT_LINE.
- Receive path operates independently of the FSM; ack frames are also delivered to it.
  - frame_complete with rx_frame_ready=0: set rx_frame_ready=1, rx_frame_ok=frame_valid.
  - frame_complete with rx_frame_ready=1: buffer is unchanged, rx_overrun=1.
  - host_rx_release clears rx_frame_ready, rx_frame_ok and rx_overrun. If it coincides with frame_complete, the release applies first and the new frame is captured with no overrun.
  - abort increments abort_count, saturating at 255.
- Registered outputs; event-to-pulse latency is 1 clk.

Decomposition:
- Shared package: state encodings, LFSR seed and taps, backoff scale (16).
- One natural sub-module: sync2 (2-flop synchronizer, async reset), instanced twice.
- The LFSR stays inline.

Test Plan:
- Idle rise then tx_req=1: tx_start pulses exactly 64+2 clk after idle_in rises (+1 registered) and tx_grant=1. An idle drop at cycle 30 restarts the count.
- tx_done then frame_complete with frame_valid=1 after 500 clk: tx_ok pulses, state=0, rx_frame_ready=1, rx_frame_ok=1, irq=1.
- No ack response, three times: two BACKOFF entries with retry_count 1 then 2, backoff lengths equal to 16*LFSR sample; the third timeout (2000 clk) gives tx_fail and state=0.
- no_clock_in=1 during TX: within 3 clk tx_grant=0, tx_fail pulses once, state=5. Deassertion returns to state 0.
- Two frame_complete pulses with no release: rx_overrun=1 and rx_frame_ok keeps the first frame_valid. Release coincident with a third frame: ready=1, overrun=0.
- 300 abort pulses: abort_count=255. Reset asserted mid-BACKOFF: all outputs 0 asynchronously, state=0.
